// File: rtl/telemetry_frame_builder_pkg.sv
// Shared types and constants for the telemetry frame builder.
// Frame layout: 'A' h5..h0 ' ' 'T' h3..h0 ' ' 'B' h1 h0 CR LF.
package telemetry_frame_builder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_RDY  = 3'd2,
        ST_GUARD     = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    localparam int         FRAME_LEN = 19;
    localparam logic [4:0] LAST_IDX  = 5'(FRAME_LEN - 1);

    localparam logic [7:0] CH_A    = 8'h41;
    localparam logic [7:0] CH_T    = 8'h54;
    localparam logic [7:0] CH_B    = 8'h42;
    localparam logic [7:0] CH_SP   = 8'h20;
    localparam logic [7:0] CH_DASH = 8'h2D;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;

endpackage

// File: rtl/telemetry_frame_builder_nibble_to_ascii.sv
// Converts one 4-bit nibble into its uppercase ASCII hex character.
module telemetry_frame_builder_nibble_to_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    assign ascii = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                    : (8'h37 + {4'h0, nibble});

endmodule

// File: rtl/telemetry_frame_builder.sv
// Periodic telemetry line builder: snapshots ADC/temperature/bill count on each
// frame tick and streams the ASCII-hex line into the UART transmitter.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for a frame tick; snapshot taken on the tick
// LOAD      | latch char(idx) onto tx_data
// WAIT_RDY  | wait for tx_busy low, then strobe tx_start
// GUARD     | skip one cycle while the UART raises tx_busy
// WAIT_DONE | wait for the byte to finish, then next byte or IDLE
module telemetry_frame_builder
    import telemetry_frame_builder_pkg::*;
#(
    parameter int FRAME_PERIOD = 10000,
    parameter int ADC_W        = 24
) (
    input  logic        CLK_10MHZ,
    input  logic        rst_n,
    input  logic [23:0] adc_data,
    input  logic        adc_valid,
    input  logic [15:0] temperature,
    input  logic [7:0]  bill_accumed,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        frame_active,
    output logic [7:0]  overrun_cnt
);

    localparam int               CNT_W    = $clog2(FRAME_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PERIOD - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic [23:0]      adc_hold;
    logic             adc_fresh;
    logic [23:0]      sh_adc;
    logic             sh_fresh;
    logic [15:0]      sh_temp;
    logic [7:0]       sh_bill;
    logic [4:0]       idx;
    logic [3:0]       nib;
    logic [7:0]       nib_ascii;
    logic [7:0]       lit;
    logic             use_nib;
    logic [7:0]       char_byte;

    assign tick = (cnt == CNT_LAST);

    telemetry_frame_builder_nibble_to_ascii u_nibble_to_ascii (
        .nibble (nib),
        .ascii  (nib_ascii)
    );

    always_comb begin
        nib     = 4'h0;
        use_nib = 1'b1;
        lit     = CH_SP;
        case (idx)
            5'd0:    begin use_nib = 1'b0; lit = CH_A; end
            5'd1:    nib = sh_adc[23:20];
            5'd2:    nib = sh_adc[19:16];
            5'd3:    nib = sh_adc[15:12];
            5'd4:    nib = sh_adc[11:8];
            5'd5:    nib = sh_adc[7:4];
            5'd6:    nib = sh_adc[3:0];
            5'd7:    begin use_nib = 1'b0; lit = CH_SP; end
            5'd8:    begin use_nib = 1'b0; lit = CH_T; end
            5'd9:    nib = sh_temp[15:12];
            5'd10:   nib = sh_temp[11:8];
            5'd11:   nib = sh_temp[7:4];
            5'd12:   nib = sh_temp[3:0];
            5'd13:   begin use_nib = 1'b0; lit = CH_SP; end
            5'd14:   begin use_nib = 1'b0; lit = CH_B; end
            5'd15:   nib = sh_bill[7:4];
            5'd16:   nib = sh_bill[3:0];
            5'd17:   begin use_nib = 1'b0; lit = CH_CR; end
            default: begin use_nib = 1'b0; lit = CH_LF; end
        endcase
        // A stale ADC value is shown as dashes rather than repeating old data.
        if (!sh_fresh && (idx >= 5'd1) && (idx <= 5'd6)) begin
            use_nib = 1'b0;
            lit     = CH_DASH;
        end
    end

    assign char_byte = use_nib ? nib_ascii : lit;

    // tx_start is decoded from state so it falls with the async reset.
    always_comb begin
        next_state = state;
        tx_start   = 1'b0;
        case (state)
            ST_IDLE:      if (tick) next_state = ST_LOAD;
            ST_LOAD:      next_state = ST_WAIT_RDY;
            ST_WAIT_RDY: begin
                if (!tx_busy) begin
                    tx_start   = 1'b1;
                    next_state = ST_GUARD;
                end
            end
            ST_GUARD:     next_state = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (!tx_busy) next_state = (idx == LAST_IDX) ? ST_IDLE : ST_LOAD;
            end
            default:      next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            adc_hold     <= '0;
            adc_fresh    <= 1'b0;
            sh_adc       <= '0;
            sh_fresh     <= 1'b0;
            sh_temp      <= '0;
            sh_bill      <= '0;
            idx          <= '0;
            tx_data      <= '0;
            frame_active <= 1'b0;
            overrun_cnt  <= '0;
        end else begin
            state <= next_state;
            cnt   <= tick ? '0 : cnt + 1'b1;

            if (tick && (state == ST_IDLE)) begin
                sh_adc       <= adc_hold;
                sh_fresh     <= adc_fresh;
                sh_temp      <= temperature;
                sh_bill      <= bill_accumed;
                adc_fresh    <= 1'b0;
                idx          <= '0;
                frame_active <= 1'b1;
            end

            // Placed after the snapshot so a coincident sample wins over the clear.
            if (adc_valid) begin
                adc_hold  <= 24'(adc_data[ADC_W-1:0]);
                adc_fresh <= 1'b1;
            end

            if (tick && frame_active && (overrun_cnt != 8'hFF))
                overrun_cnt <= overrun_cnt + 8'd1;

            if (state == ST_LOAD)
                tx_data <= char_byte;

            if ((state == ST_WAIT_DONE) && !tx_busy) begin
                if (idx == LAST_IDX) frame_active <= 1'b0;
                else                 idx <= idx + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_telemetry_frame_builder.sv
// Self-checking bench for telemetry_frame_builder with a simple UART busy model
// and a string-level reference model of the transmitted line.
module tb_telemetry_frame_builder;

    localparam int PERIOD = 200;

    logic        CLK_10MHZ = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] adc_data = '0;
    logic        adc_valid = 1'b0;
    logic [15:0] temperature = '0;
    logic [7:0]  bill_accumed = '0;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        frame_active;
    logic [7:0]  overrun_cnt;

    int checks = 0;
    int errors = 0;

    int   hold_len = 20;
    int   busy_cnt = 0;
    logic force_busy = 1'b0;

    telemetry_frame_builder #(.FRAME_PERIOD(PERIOD), .ADC_W(24)) dut (
        .CLK_10MHZ    (CLK_10MHZ),
        .rst_n        (rst_n),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .temperature  (temperature),
        .bill_accumed (bill_accumed),
        .tx_busy      (tx_busy),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .frame_active (frame_active),
        .overrun_cnt  (overrun_cnt)
    );

    always #5 CLK_10MHZ = ~CLK_10MHZ;

    // UART model: busy rises the cycle after a start and stays high hold_len cycles.
    assign tx_busy = (busy_cnt != 0) || force_busy;
    always @(posedge CLK_10MHZ) begin
        if (tx_start)          busy_cnt <= hold_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    // Monitor: tick times from the period rule, captured bytes, protocol violations.
    int          pe = 0;
    int          edge_n = 0;
    logic        prev_start = 1'b0;
    logic [7:0]  rx_q[$];
    int          start_q[$];
    int          tick_q[$];
    int          viol_busy = 0;
    int          viol_width = 0;
    int          viol_stable = 0;

    always @(posedge CLK_10MHZ) begin
        edge_n <= edge_n + 1;
        if (!rst_n) begin
            pe         <= 0;
            prev_start <= 1'b0;
        end else begin
            pe         <= pe + 1;
            prev_start <= tx_start;
            if (pe % PERIOD == PERIOD - 1) tick_q.push_back(edge_n);
            if (tx_start) begin
                rx_q.push_back(tx_data);
                start_q.push_back(edge_n);
                if (tx_busy)    viol_busy  <= viol_busy + 1;
                if (prev_start) viol_width <= viol_width + 1;
            end
            if (busy_cnt == 1 && frame_active && rx_q.size() > 0 && tx_data !== rx_q[$])
                viol_stable <= viol_stable + 1;
        end
    end

    // Reference model state
    logic [23:0] m_hold = '0;
    logic        m_fresh = 1'b0;
    logic [23:0] s_hold;
    logic        s_fresh;
    logic [15:0] s_temp;
    logic [7:0]  s_bill;
    logic [7:0]  exp_f [19];
    int rx_base, st_base, vb_base, vw_base, vs_base;

    function automatic logic [7:0] hexch(input logic [3:0] n);
        string h;
        h = "0123456789ABCDEF";
        return 8'(h.getc(int'(n)));
    endfunction

    task automatic build_exp();
        exp_f[0] = "A";
        for (int i = 0; i < 6; i++)
            exp_f[1+i] = s_fresh ? hexch(s_hold[23-4*i -: 4]) : 8'h2D;
        exp_f[7] = 8'h20;
        exp_f[8] = "T";
        for (int i = 0; i < 4; i++) exp_f[9+i] = hexch(s_temp[15-4*i -: 4]);
        exp_f[13] = 8'h20;
        exp_f[14] = "B";
        exp_f[15] = hexch(s_bill[7:4]);
        exp_f[16] = hexch(s_bill[3:0]);
        exp_f[17] = 8'h0D;
        exp_f[18] = 8'h0A;
    endtask

    task automatic snap();
        s_hold  = m_hold;
        s_fresh = m_fresh;
        s_temp  = temperature;
        s_bill  = bill_accumed;
        m_fresh = 1'b0;
    endtask

    task automatic mark();
        rx_base = rx_q.size();
        st_base = start_q.size();
        vb_base = viol_busy;
        vw_base = viol_width;
        vs_base = viol_stable;
    endtask

    task automatic drive_adc(input logic [23:0] d);
        if (pe % PERIOD == PERIOD - 1) @(negedge CLK_10MHZ);
        adc_data  = d;
        adc_valid = 1'b1;
        @(negedge CLK_10MHZ);
        adc_valid = 1'b0;
        m_hold    = d;
        m_fresh   = 1'b1;
    endtask

    task automatic wait_level(input logic lvl, input int budget, input string name);
        for (int i = 0; i < budget && frame_active !== lvl; i++) @(negedge CLK_10MHZ);
        checks++;
        if (frame_active !== lvl) begin
            errors++;
            $display("FAIL %s: frame_active timed out, got %b want %b", name, frame_active, lvl);
        end
    endtask

    task automatic wait_bytes(input int n, input string name);
        for (int i = 0; i < 40 * (hold_len + 3) && (rx_q.size() - rx_base) < n; i++)
            @(negedge CLK_10MHZ);
        checks++;
        if ((rx_q.size() - rx_base) < n) begin
            errors++;
            $display("FAIL %s: only %0d bytes seen, want %0d", name, rx_q.size() - rx_base, n);
        end
    endtask

    task automatic begin_frame(input string name);
        mark();
        wait_level(1'b1, 2 * PERIOD + 10, name);
        snap();
    endtask

    task automatic collect(input string name, input bit timing);
        int n, bad, t0, s0;
        build_exp();
        wait_level(1'b0, 19 * (hold_len + 3) + 50, name);
        n = rx_q.size() - rx_base;
        checks++;
        if (n != 19) begin
            errors++;
            $display("FAIL %s_len: got %0d bytes want 19", name, n);
        end else begin
            bad = -1;
            for (int i = 18; i >= 0; i--) if (rx_q[rx_base+i] !== exp_f[i]) bad = i;
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL %s_bytes: byte %0d got %h want %h", name, bad, rx_q[rx_base+bad], exp_f[bad]);
            end
        end
        checks++;
        if (viol_busy != vb_base || viol_width != vw_base || viol_stable != vs_base) begin
            errors++;
            $display("FAIL %s_protocol: busy_starts %0d wide_strobes %0d data_changes %0d want 0 0 0",
                     name, viol_busy - vb_base, viol_width - vw_base, viol_stable - vs_base);
        end
        if (timing && n == 19) begin
            s0 = start_q[st_base];
            t0 = -1;
            foreach (tick_q[i]) if (tick_q[i] < s0) t0 = tick_q[i];
            checks++;
            if (s0 - t0 != 2) begin
                errors++;
                $display("FAIL %s_latency: tick to first start %0d cycles want 2", name, s0 - t0);
            end
            bad = -1;
            for (int i = 1; i < 19; i++)
                if (start_q[st_base+i] - start_q[st_base+i-1] != hold_len + 3) bad = i;
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL %s_spacing: byte %0d start gap %0d want %0d", name, bad,
                         start_q[st_base+bad] - start_q[st_base+bad-1], hold_len + 3);
            end
        end
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if (tx_start !== 1'b0 || tx_data !== 8'h00 || frame_active !== 1'b0 || overrun_cnt !== 8'h00) begin
            errors++;
            $display("FAIL %s: start=%b data=%h active=%b overrun=%h want all 0",
                     name, tx_start, tx_data, frame_active, overrun_cnt);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge CLK_10MHZ);
        rst_n   = 1'b1;
        m_hold  = '0;
        m_fresh = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge CLK_10MHZ);
        check_zero_outputs("reset_held");
        repeat (2) @(negedge CLK_10MHZ);
        rst_n = 1'b1;
        @(negedge CLK_10MHZ);
        check_zero_outputs("reset_released");
    endtask

    task automatic test_basic();
        string got;
        temperature  = 16'h0191;
        bill_accumed = 8'h05;
        drive_adc(24'h12AB9F);
        begin_frame("basic");
        collect("basic", 1'b1);
        got = "";
        for (int i = 0; i < 19 && rx_base + i < rx_q.size(); i++)
            got = $sformatf("%s%c", got, rx_q[rx_base+i]);
        checks++;
        if (got != "A12AB9F T0191 B05\r\n") begin
            errors++;
            $display("FAIL basic_text: got \"%s\" want \"A12AB9F T0191 B05\\r\\n\"", got);
        end
    endtask

    task automatic test_no_fresh();
        begin_frame("stale");
        collect("stale", 1'b1);
        begin_frame("still_stale");
        collect("still_stale", 1'b1);
    endtask

    task automatic test_busy_hold();
        force_busy = 1'b1;
        begin_frame("busy_hold");
        repeat (50) @(negedge CLK_10MHZ);
        checks++;
        if (rx_q.size() != rx_base) begin
            errors++;
            $display("FAIL busy_hold_early: got %0d starts while busy want 0", rx_q.size() - rx_base);
        end
        force_busy = 1'b0;
        collect("busy_hold", 1'b0);
    endtask

    task automatic test_midframe_change();
        temperature  = 16'($urandom);
        bill_accumed = 8'($urandom);
        begin_frame("midframe");
        wait_bytes(5, "midframe_wait");
        temperature  = ~s_temp;
        bill_accumed = ~s_bill;
        collect("midframe", 1'b1);
    endtask

    task automatic test_simultaneous();
        logic [23:0] a, b;
        a = 24'($urandom);
        b = 24'($urandom);
        drive_adc(a);
        for (int i = 0; i < 2 * PERIOD && !((pe % PERIOD == PERIOD - 1) && !frame_active); i++)
            @(negedge CLK_10MHZ);
        mark();
        adc_data  = b;
        adc_valid = 1'b1;
        @(negedge CLK_10MHZ);
        adc_valid = 1'b0;
        wait_level(1'b1, 4, "simul_start");
        snap();
        m_hold  = b;
        m_fresh = 1'b1;
        collect("simul_old", 1'b1);
        begin_frame("simul_new");
        collect("simul_new", 1'b1);
    endtask

    task automatic test_random();
        for (int f = 0; f < 5; f++) begin
            temperature  = 16'($urandom);
            bill_accumed = 8'($urandom);
            if ($urandom_range(0, 1) == 1) drive_adc(24'($urandom));
            begin_frame("random");
            if ($urandom_range(0, 1) == 1) begin
                wait_bytes($urandom_range(1, 17), "random_wait");
                temperature = 16'($urandom);
                drive_adc(24'($urandom));
            end
            collect("random", 1'b1);
        end
    endtask

    task automatic test_reset_midframe();
        temperature  = 16'($urandom);
        bill_accumed = 8'($urandom);
        begin_frame("rst_mid");
        wait_bytes(9, "rst_mid_wait");
        #3;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("rst_mid_async");
        @(negedge CLK_10MHZ);
        repeat (2) @(negedge CLK_10MHZ);
        rst_n   = 1'b1;
        m_hold  = '0;
        m_fresh = 1'b0;
        temperature  = 16'($urandom);
        bill_accumed = 8'($urandom);
        begin_frame("after_rst");
        collect("after_rst", 1'b1);
    endtask

    task automatic test_overrun();
        int t0, fin, expc;
        do_reset();
        hold_len     = 300;
        temperature  = 16'($urandom);
        bill_accumed = 8'($urandom);
        drive_adc(24'($urandom));
        begin_frame("overrun");
        collect("overrun", 1'b1);
        t0 = -1;
        foreach (tick_q[i]) if (tick_q[i] < start_q[st_base]) t0 = tick_q[i];
        fin  = t0 + 2 + 18 * (hold_len + 3) + hold_len + 1;
        expc = 0;
        foreach (tick_q[i]) if (tick_q[i] > t0 && tick_q[i] <= fin) expc++;
        checks++;
        if (int'(overrun_cnt) != expc) begin
            errors++;
            $display("FAIL overrun_count: got %0d want %0d", overrun_cnt, expc);
        end
        hold_len = 20;
        temperature = 16'($urandom);
        begin_frame("saturate");
        wait_bytes(3, "saturate_wait");
        force_busy = 1'b1;
        repeat (300 * PERIOD + 50) @(negedge CLK_10MHZ);
        checks++;
        if (overrun_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL overrun_saturate: got %0d want 255", overrun_cnt);
        end
        force_busy = 1'b0;
        collect("saturate", 1'b0);
        checks++;
        if (overrun_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL overrun_hold: got %0d want 255", overrun_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_fresh();
        test_busy_hold();
        test_midframe_change();
        test_simultaneous();
        test_random();
        test_reset_midframe();
        test_overrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
